// File: rtl/uparc_regfile_pkg.sv
// Shared constants and types for the uparc register file.
// Optional feature macro: UPARC_RF_BYPASS_EN (write-to-read forwarding), off by default.
package uparc_regfile_pkg;

  localparam int UPARC_REGNO_WIDTH = 5;
  localparam int UPARC_REG_WIDTH   = 32;
  localparam int RF_NREGS          = 1 << UPARC_REGNO_WIDTH;
  localparam int RF_NRD            = 2;   // read ports: 0 = rs, 1 = rt

  localparam logic [UPARC_REGNO_WIDTH-1:0] RF_FIRST = UPARC_REGNO_WIDTH'(1);
  localparam logic [UPARC_REGNO_WIDTH-1:0] RF_LAST  = UPARC_REGNO_WIDTH'(RF_NREGS - 1);

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // One write into the storage array, from either the clear engine or writeback.
  typedef struct packed {
    logic                         we;
    logic [UPARC_REGNO_WIDTH-1:0] no;
    logic [UPARC_REG_WIDTH-1:0]   val;
  } rf_wr_t;

endpackage

// File: rtl/uparc_regfile_clr.sv
// Post-reset clear sequencer: walks r1..r31 writing zero, then hands over to RUN.
module uparc_regfile_clr
  import uparc_regfile_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  output logic                         o_busy,
  output logic                         o_clr_we,
  output logic [UPARC_REGNO_WIDTH-1:0] o_clr_no
);

  rf_state_e                    state, state_nx;
  logic [UPARC_REGNO_WIDTH-1:0] cnt, cnt_nx;

  // State and clear pointer; reset always restarts the sweep at r1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      cnt   <= RF_FIRST;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state, busy flag and clear strobe; no clear write while rst is high.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    o_busy   = 1'b0;
    o_clr_we = 1'b0;
    o_clr_no = cnt;
    case (state)
      RF_CLEAR: begin
        o_busy   = 1'b1;
        o_clr_we = ~rst;
        if (cnt == RF_LAST) begin
          state_nx = RF_RUN;
          cnt_nx   = RF_FIRST;
        end else begin
          cnt_nx   = cnt + 1'b1;
        end
      end
      RF_RUN:  ;
      default: state_nx = RF_CLEAR;
    endcase
  end

endmodule

// File: rtl/uparc_regfile.sv
// Two-read, one-write GPR file with registered read data and a post-reset clear.
// r0 is hardwired to zero and has no storage.
// Define UPARC_RF_BYPASS_EN to forward same-cycle writeback data to the read outputs.
module uparc_regfile
  import uparc_regfile_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_stall,
  input  logic [UPARC_REGNO_WIDTH-1:0] i_rs_no,
  input  logic [UPARC_REGNO_WIDTH-1:0] i_rt_no,
  output logic [UPARC_REG_WIDTH-1:0]   o_rs_val,
  output logic [UPARC_REG_WIDTH-1:0]   o_rt_val,
  input  logic [UPARC_REGNO_WIDTH-1:0] i_rd_no,
  input  logic [UPARC_REG_WIDTH-1:0]   i_rd_val,
  output logic                         o_init_busy
);

  logic                                       clr_we;
  logic [UPARC_REGNO_WIDTH-1:0]               clr_no;
  rf_wr_t                                     wr;
  logic [UPARC_REG_WIDTH-1:0]                 mem [1:RF_NREGS-1];
  logic [RF_NRD-1:0][UPARC_REGNO_WIDTH-1:0]   rd_no;
  logic [RF_NRD-1:0][UPARC_REG_WIDTH-1:0]     rd_nx;
  logic [RF_NRD-1:0][UPARC_REG_WIDTH-1:0]     rd_q;

  assign rd_no    = {i_rt_no, i_rs_no};
  assign o_rs_val = rd_q[0];
  assign o_rt_val = rd_q[1];

  uparc_regfile_clr u_clr (
    .clk      (clk),
    .rst      (rst),
    .o_busy   (o_init_busy),
    .o_clr_we (clr_we),
    .o_clr_no (clr_no)
  );

  // Write source select: clear engine owns the array while busy; writeback
  // is ignored in CLEAR and during reset, and a target of r0 is dropped.
  always_comb begin
    wr = '0;
    if (clr_we) begin
      wr.we  = 1'b1;
      wr.no  = clr_no;
      wr.val = '0;
    end else if (!o_init_busy && !rst && (i_rd_no != '0)) begin
      wr.we  = 1'b1;
      wr.no  = i_rd_no;
      wr.val = i_rd_val;
    end
  end

  // Storage update; deliberately not gated by stall.
  always_ff @(posedge clk) begin
    if (wr.we) mem[wr.no] <= wr.val;
  end

  // Per-port read mux: r0 reads zero, optionally forward the in-flight write.
  always_comb begin
    rd_nx = '0;
    for (int p = 0; p < RF_NRD; p++) begin
      if (rd_no[p] != '0) begin
        rd_nx[p] = mem[rd_no[p]];
`ifdef UPARC_RF_BYPASS_EN
        if (wr.we && (wr.no == rd_no[p])) rd_nx[p] = wr.val;
`endif
      end
    end
  end

  // Read output registers: zero in reset/CLEAR, hold on stall.
  always_ff @(posedge clk) begin
    if (rst || o_init_busy) begin
      rd_q <= '0;
    end else if (!i_stall) begin
      rd_q <= rd_nx;
    end
  end

endmodule

// File: tb/tb_uparc_regfile.sv
// Directed self-checking bench for uparc_regfile with an expectation queue.
module tb_uparc_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall = 1'b0;
  logic [4:0]  i_rs_no = '0;
  logic [4:0]  i_rt_no = '0;
  logic [4:0]  i_rd_no = '0;
  logic [31:0] i_rd_val = '0;
  logic [31:0] o_rs_val, o_rt_val;
  logic        o_init_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t sbq[$];

`ifdef UPARC_RF_BYPASS_EN
  localparam logic [31:0] HAZ = 32'h2;
`else
  localparam logic [31:0] HAZ = 32'h1;
`endif

  uparc_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (i_stall),
    .i_rs_no     (i_rs_no),
    .i_rt_no     (i_rt_no),
    .o_rs_val    (o_rs_val),
    .o_rt_val    (o_rt_val),
    .i_rd_no     (i_rd_no),
    .i_rd_val    (i_rd_val),
    .o_init_busy (o_init_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the read outputs.
  task automatic pop_check();
    exp_t e;
    total++;
    assert (sbq.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty obs=0 exp=1");
      return;
    end
    e = sbq.pop_front();
    total++;
    assert (o_rs_val === e.rs) else begin
      bad++;
      $error("FAIL %s.rs obs=%h exp=%h", e.tag, o_rs_val, e.rs);
    end
    total++;
    assert (o_rt_val === e.rt) else begin
      bad++;
      $error("FAIL %s.rt obs=%h exp=%h", e.tag, o_rt_val, e.rt);
    end
  endtask

  // One cycle of stimulus; if chk, expected outputs after the edge are queued.
  task automatic op(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd, input logic [31:0] val, input logic stall,
                    input logic chk, input logic [31:0] ers, input logic [31:0] ert);
    exp_t e;
    i_rs_no  = rs;
    i_rt_no  = rt;
    i_rd_no  = rd;
    i_rd_val = val;
    i_stall  = stall;
    if (chk) begin
      e.tag = tag; e.rs = ers; e.rt = ert;
      sbq.push_back(e);
    end
    tick();
    if (chk) pop_check();
    i_rd_no = '0;
    i_stall = 1'b0;
  endtask

  // One reset cycle: outputs zero and busy raised right after the edge.
  task automatic do_rst(input string tag);
    exp_t e;
    rst = 1'b1;
    i_rs_no = 5'd31; i_rt_no = 5'd10; i_rd_no = 5'd4; i_rd_val = 32'h77;
    e.tag = tag; e.rs = '0; e.rt = '0;
    sbq.push_back(e);
    tick();
    pop_check();
    chk_bit({tag, ".busy"}, o_init_busy, 1'b1);
    rst = 1'b0;
    i_rd_no = '0;
  endtask

  // Run CLEAR to completion with a write attempt to r5 each cycle; outputs
  // must stay zero and busy must last exactly 31 cycles.
  task automatic wait_clear(input string tag, input int already);
    int n = already;
    while (o_init_busy && n < 64) begin
      op({tag, ".out"}, 5'd31, 5'd10, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 32'h0);
      n++;
    end
    chk_int({tag, ".cycles"}, n, 31);
  endtask

  initial begin
    // Reset and initial clear
    do_rst("rst0");
    wait_clear("clr0", 0);
    op("clr_r5",   5'd5, 5'd5, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Basic write then read
    op("wr7",      5'd0, 5'd0, 5'd7, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
    op("rd7",      5'd7, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h12345678, 32'h0);

    // r0 protection, and rs == rt
    op("wr0",      5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0);
    op("rd0",      5'd0, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h12345678);
    op("same",     5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1, 32'h12345678, 32'h12345678);

    // Same-cycle write/read hazard
    op("wr3",      5'd0, 5'd0, 5'd3, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    op("haz",      5'd3, 5'd3, 5'd3, 32'h2, 1'b0, 1'b1, HAZ, HAZ);
    op("haz_post", 5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h2, 32'h0);

    // Stall hold while address changes and r9 is written
    op("wr10",     5'd0, 5'd0, 5'd10, 32'hA, 1'b0, 1'b0, 32'h0, 32'h0);
    op("rdA",      5'd10, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hA, 32'h0);
    op("stl1",     5'd9, 5'd9, 5'd9, 32'hB, 1'b1, 1'b1, 32'hA, 32'h0);
    op("stl2",     5'd3, 5'd7, 5'd0, 32'h0, 1'b1, 1'b1, 32'hA, 32'h0);
    op("stl3",     5'd7, 5'd3, 5'd0, 32'h0, 1'b1, 1'b1, 32'hA, 32'h0);
    op("stl_rel",  5'd9, 5'd10, 5'd0, 32'h0, 1'b0, 1'b1, 32'hB, 32'hA);

    // Top register boundary; r1 still holds its cleared value
    op("wr31",     5'd0, 5'd0, 5'd31, 32'h31313131, 1'b0, 1'b0, 32'h0, 32'h0);
    op("rd31",     5'd31, 5'd1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h31313131, 32'h0);

    // Reset on the tenth cycle of CLEAR restarts a full sweep
    do_rst("rst1");
    for (int i = 0; i < 9; i++)
      op("clr1.out", 5'd31, 5'd7, 5'd4, 32'h99, 1'b0, 1'b1, 32'h0, 32'h0);
    chk_bit("clr1.busy9", o_init_busy, 1'b1);
    do_rst("rst2");
    wait_clear("clr2", 0);

    // Reset in RUN after r4 is written; r4 and r31 read zero afterwards
    op("wr4",      5'd0, 5'd0, 5'd4, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
    op("rd4",      5'd4, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h55, 32'h0);
    op("wr31b",    5'd0, 5'd0, 5'd31, 32'hCAFE, 1'b0, 1'b0, 32'h0, 32'h0);
    do_rst("rst3");
    wait_clear("clr3", 0);
    op("rd4_clr",  5'd4, 5'd31, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);
    op("rd7_clr",  5'd7, 5'd9, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uparc_regfile.md
UPARC_REGFILE -- requirements
Module: uparc_regfile

Interface
REQ-001 SHALL have constant UPARC_REGNO_WIDTH, default 5, meaning register number width (32 GPRs).
REQ-002 SHALL have constant UPARC_REG_WIDTH, default 32, meaning register value width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port i_stall  input  1  meaning core stall; the read outputs hold while it is 1.
REQ-006 SHALL have port i_rs_no  input  UPARC_REGNO_WIDTH  meaning read port A register number.
REQ-007 SHALL have port i_rt_no  input  UPARC_REGNO_WIDTH  meaning read port B register number.
REQ-008 SHALL have port o_rs_val  output  UPARC_REG_WIDTH  meaning registered read port A data.
REQ-009 SHALL have port o_rt_val  output  UPARC_REG_WIDTH  meaning registered read port B data.
REQ-010 SHALL have port i_rd_no  input  UPARC_REGNO_WIDTH  meaning write register number from writeback; 0 means no write.
REQ-011 SHALL have port i_rd_val  input  UPARC_REG_WIDTH  meaning write data from writeback.
REQ-012 SHALL have port o_init_busy  output  1  meaning the post-reset clear sequence is in progress.

Function
REQ-013 SHALL hold 31 storage registers (r1..r31); r0 SHALL always read 0 and SHALL never be stored.
REQ-014 SHALL implement an FSM with states CLEAR and RUN.
REQ-015 SHALL, in CLEAR, write 0 to r[cnt] each cycle, cnt running 1..31; after the write to r31 it SHALL enter RUN (31 cycles busy).
REQ-016 SHALL drive o_init_busy=1 in CLEAR and 0 in RUN.
REQ-017 SHALL ignore i_rd_no/i_rd_val in CLEAR and SHALL load o_rs_val/o_rt_val with 0 in CLEAR.
REQ-018 SHALL, in RUN, write i_rd_val into r[i_rd_no] at the clock edge when i_rd_no!=0; writes SHALL NOT be gated by i_stall.
REQ-019 SHALL, in RUN with i_stall=0, load o_rs_val/o_rt_val with the addressed contents (0 for register 0), so data appears 1 cycle after the address.
REQ-020 SHALL, with i_stall=1, hold o_rs_val/o_rt_val unchanged.
REQ-021 SHALL serve rs==rt correctly, with both outputs equal.
REQ-022 SHALL allow a write and a read of the same register in one cycle; the result is defined by REQ-027/REQ-028.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set o_rs_val=0, o_rt_val=0, o_init_busy=1, state=CLEAR and cnt=1.
REQ-024 SHALL, on rst asserted mid-CLEAR or in RUN, abort the current activity and restart the clear at r1.
REQ-025 SHALL NOT perform any write during a cycle in which rst=1.

Configuration
REQ-026 SHALL have macro UPARC_RF_BYPASS_EN, which enables write-to-read forwarding.
REQ-027 SHALL, when UPARC_RF_BYPASS_EN is defined, load i_rd_val into a read output in RUN with i_stall=0 whenever i_rd_no!=0 and i_rd_no equals that port's register number.
REQ-028 SHALL, when UPARC_RF_BYPASS_EN is undefined, return the pre-write contents for the same-cycle case of REQ-027.

Structure
REQ-029 SHALL take UPARC_REGNO_WIDTH and UPARC_REG_WIDTH from the shared uparc_cpu_common.vh.
REQ-030 SHALL take the FSM state encodings and UPARC_RF_BYPASS_EN default from uparc_cpu_config.vh and uparc_cpu_const.vh.
REQ-031 SHALL contain one sub-module, uparc_regfile_clr, which holds the CLEAR/RUN FSM and cnt and drives o_init_busy and the clear write strobe/address.

Verification
REQ-032 SHALL cover reset clear: rst 1 cycle, then write r5=0xDEADBEEF during CLEAR -> o_init_busy high exactly 31 cycles; a read of r5 after RUN returns 0.
REQ-033 SHALL cover basic write/read: in RUN, write r7=0x12345678, next cycle rs=7, rt=0 -> o_rs_val=0x12345678 and o_rt_val=0 one cycle later.
REQ-034 SHALL cover r0 protection: write r0=0xFFFFFFFF, then read r0 -> 0.
REQ-035 SHALL cover same-cycle hazard: r3=0x1, then in one cycle write r3=0x2 and read rs=3 -> o_rs_val=0x2 with bypass, 0x1 without.
REQ-036 SHALL cover stall hold: o_rs_val=0xA, i_stall=1 for 3 cycles while rs changes and r9=0xB is written -> o_rs_val stays 0xA; after release, reading r9 gives 0xB.
REQ-037 SHALL cover mid-operation reset: rst at cycle 10 of CLEAR, then again in RUN after r4=0x55 -> o_init_busy restarts a full 31 cycles and r4 then reads 0.
